count_xor_scrambler: RTL and testbench
======================================

Name: count_xor_scrambler

Overview:
- Parametrised successor to the 8-bit up/down count XOR stage. Each accepted data word is XORed with a running count to produce the output word.
- Adds the following over the 8-bit stage:
  - WIDTH and STEP generics
  - explicit count-mode select
  - wrap or saturate arithmetic
  - synchronous count load
  - valid/ready handshake with a registered output stage
- Sits inline on a datapath between a producer and a consumer, both with valid/ready.

Parameters:
- WIDTH, 8: data and count width in bits (≥2).
- STEP, 1: count increment/decrement magnitude. Must satisfy 1 ≤ STEP < 2^WIDTH.
- SATURATE, 0: 0 = count wraps modulo 2^WIDTH; 1 = count clamps at 0 and at 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- mode  input  2  count mode:
  - 00 = direction from in_data MSB (1 up, 0 down)
  - 01 = always up
  - 10 = always down
  - 11 = hold
- load  input  1  synchronous count load strobe.
- load_value  input  WIDTH  value taken by count on load.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  data word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer takes the word.
- out_data  output  WIDTH  scrambled word.
- out_event  output  1  wrap/saturation event for the word in out_data.
- count_q  output  WIDTH  current count, for debug/observation.

Behaviour:
- Reset (clear high, asynchronous): count_q=0, out_valid=0, out_data=0, out_event=0. Reset asserted mid-transfer discards the held word; no partial state survives.
- in_ready = !out_valid || out_ready (combinational). Single output register, no skid buffer.
- Accept = in_valid && in_ready. On accept at edge k:
  - out_data <= in_data ^ count_q, using the pre-update count.
  - out_valid <= 1.
  - count updates per mode.
  - Latency: 1 cycle, input edge to out_valid.
- Output hold: when out_valid=1 and out_ready=0, out_data and out_event hold stable. Count does not change, except by load.
- When out_ready=1 and there is no accept: out_valid <= 0.
- Count update, applied only on accept and only when load=0:
  - up: count + STEP.
  - down: count - STEP.
  - hold: unchanged.
  - Arithmetic is computed in WIDTH+1 bits.
- Wrap mode (SATURATE=0): result truncated to WIDTH bits. out_event=1 if the addition carried out or the subtraction borrowed.
- Saturate mode (SATURATE=1): result clamped to 2^WIDTH-1 on overflow, or to 0 on underflow. out_event=1 when clamping occurred.
  - Already at the limit and stepping further: count stays put, out_event=1.
- out_event is registered alongside out_data; it is 0 for hold mode and for loaded cycles.
- Load (load=1): count <= load_value, regardless of accept.
  - If accept coincides with load, that word is XORed with the pre-load count_q, and load wins over the count step.
- mode is sampled only on accept; changing mode while stalled has no effect.
- Mode 00 uses in_data[WIDTH-1] of the accepted word.

Optional Feature:
- Macro: COUNT_XOR_SCRAMBLER_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR-reduce) of out_data.
  - Registered with out_data; resets to 0; holds under stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package count_xor_pkg:
  - typedef enum logic[1:0] count_mode_t {MODE_MSB, MODE_UP, MODE_DOWN, MODE_HOLD}.
  - Constant COUNT_MODE_W=2.
- Sub-module count_step_unit (combinational):
  - Inputs: count, direction/hold, STEP, SATURATE.
  - Outputs: next count and event flag.
- Top level owns the count register, load priority, handshake and output register.

Test Plan (WIDTH=8, STEP=1, SATURATE=0 unless stated):
- Reset then mode=01, stream 0x00,0x00,0x00 with out_ready=1 -> out_data 0x00,0x01,0x02 on consecutive cycles; count_q=0x03.
- Mode=00: send 0x80 then 0x00 from count 0 -> out_data 0x80 then 0x01. Count goes 1 then 0. Third word 0x00 -> out_data 0x00, count 0xFF, out_event=1.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first word; out_data stable; count_q unchanged. Release -> next word uses the old count+1.
- Load 0xFE coincident with accepting 0x0F at count 0x05 -> out_data 0x0A; count_q=0xFE next cycle. Mode 01 then gives 0xFF, then wraps to 0x00 with out_event=1.
- SATURATE=1, STEP=4, count 0xFD, mode 01 -> count 0xFF, out_event=1. Repeat -> stays 0xFF, out_event=1. Mode 10 from 0x02 -> count 0x00, out_event=1.
- Assert clear asynchronously while out_valid=1 and count=0x37 -> immediately out_valid=0, out_data=0, count_q=0; with PARITY_EN, out_parity=0.

Source files
------------

// File: rtl/count_xor_scrambler_pkg.sv
// Shared types for the count XOR scrambler: count mode encoding and its width.
package count_xor_pkg;

  localparam int COUNT_MODE_W = 2;

  typedef enum logic [COUNT_MODE_W-1:0] {
    MODE_MSB  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_HOLD = 2'b11
  } count_mode_t;

endpackage

// File: rtl/count_xor_scrambler_if.sv
// Producer/consumer valid-ready stream bundle for the scrambler.
// COUNT_XOR_SCRAMBLER_PARITY_EN adds the out_parity signal.
interface count_xor_scrambler_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_event;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
  logic             out_parity;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_event, out_parity
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_event, out_parity
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_event
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_event
  );
`endif
endinterface

// File: rtl/count_xor_scrambler_step.sv
// Combinational count stepper: +/-STEP in WIDTH+1 bits, wrapping or clamping.
// evt flags a carry/borrow (wrap) or a clamp (saturate); hold yields no event.
module count_step_unit #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             hold,
  output logic [WIDTH-1:0] next_count,
  output logic             evt
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = {1'b0, count} + STEP_X;
    diff       = {1'b0, count} - STEP_X;
    next_count = count;
    evt        = 1'b0;
    if (!hold) begin
      if (up) begin
        evt        = sum[WIDTH];
        next_count = (SATURATE != 0 && sum[WIDTH]) ? MAX_V : sum[WIDTH-1:0];
      end else begin
        // top bit of the widened difference is the borrow
        evt        = diff[WIDTH];
        next_count = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/count_xor_scrambler.sv
// XORs each accepted word with a running count; 1-cycle registered output, no skid.
// COUNT_XOR_SCRAMBLER_PARITY_EN adds a registered even-parity bit of out_data.
module count_xor_scrambler
  import count_xor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [COUNT_MODE_W-1:0] mode,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_value,
  output logic [WIDTH-1:0]        count_q,
  count_xor_scrambler_if.slave    bus
);

  count_mode_t      mode_e;
  logic             accept;
  logic             step_up;
  logic             step_hold;
  logic [WIDTH-1:0] step_next;
  logic             step_evt;

  logic [WIDTH-1:0] count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_event_q, out_event_d;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  assign mode_e      = count_mode_t'(mode);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;

  always_comb begin
    step_up   = 1'b0;
    step_hold = 1'b0;
    case (mode_e)
      MODE_MSB:  step_up   = bus.in_data[WIDTH-1];
      MODE_UP:   step_up   = 1'b1;
      MODE_DOWN: step_up   = 1'b0;
      MODE_HOLD: step_hold = 1'b1;
      default:   step_hold = 1'b1;
    endcase
  end

  count_step_unit #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_step (
    .count      (count_q),
    .up         (step_up),
    .hold       (step_hold),
    .next_count (step_next),
    .evt        (step_evt)
  );

  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_event_d = out_event_q;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    // load overrides the step but the accepted word still sees the pre-load count
    if (load) begin
      count_d = load_value;
    end else if (accept) begin
      count_d = step_next;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data ^ count_q;
      out_event_d = load ? 1'b0 : step_evt;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
      out_parity_d = ^(bus.in_data ^ count_q);
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_event_q <= 1'b0;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_event_q <= out_event_d;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_event = out_event_q;
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
  assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_count_xor_scrambler.sv
// Directed bench: wrapping STEP=1 instance (a) and saturating STEP=4 instance (b).
module tb_count_xor_scrambler;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] mode_a, mode_b;
  logic       load_a, load_b;
  logic [7:0] lv_a, lv_b;
  logic [7:0] count_a, count_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_xor_scrambler_if #(.WIDTH(8)) a_if ();
  count_xor_scrambler_if #(.WIDTH(8)) b_if ();

  count_xor_scrambler #(.WIDTH(8), .STEP(1), .SATURATE(0)) dut_a (
    .clk        (clk),
    .clear      (clear),
    .mode       (mode_a),
    .load       (load_a),
    .load_value (lv_a),
    .count_q    (count_a),
    .bus        (a_if.slave)
  );

  count_xor_scrambler #(.WIDTH(8), .STEP(4), .SATURATE(1)) dut_b (
    .clk        (clk),
    .clear      (clear),
    .mode       (mode_b),
    .load       (load_b),
    .load_value (lv_b),
    .count_q    (count_b),
    .bus        (b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    mode_a = 2'b01; load_a = 1'b0; lv_a = 8'h00;
    mode_b = 2'b01; load_b = 1'b0; lv_b = 8'h00;
    a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.out_ready = 1'b1;
    step();
    step();

    // reset state
    chk("rst_count", count_a, 8'h00);
    chk("rst_valid", a_if.out_valid, 1'b0);
    chk("rst_data", a_if.out_data, 8'h00);
    chk("rst_event", a_if.out_event, 1'b0);
    chk("rst_in_ready", a_if.in_ready, 1'b1);
    chk("rst_count_b", count_b, 8'h00);
    clear = 1'b0;

    // mode 01 stream of zeros
    a_if.in_valid = 1'b1; a_if.in_data = 8'h00;
    step();
    chk("up0_data", a_if.out_data, 8'h00);
    chk("up0_valid", a_if.out_valid, 1'b1);
    step();
    chk("up1_data", a_if.out_data, 8'h01);
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
    chk("up1_parity", a_if.out_parity, 1'b1);
`endif
    step();
    chk("up2_data", a_if.out_data, 8'h02);
    chk("up2_event", a_if.out_event, 1'b0);
    a_if.in_valid = 1'b0;
    step();
    chk("up_drain_valid", a_if.out_valid, 1'b0);
    chk("up_count", count_a, 8'h03);

    // load without accept, then mode 00 direction from data MSB
    load_a = 1'b1; lv_a = 8'h00;
    step();
    load_a = 1'b0;
    chk("ld0_count", count_a, 8'h00);
    mode_a = 2'b00; a_if.in_valid = 1'b1; a_if.in_data = 8'h80;
    step();
    chk("msb0_data", a_if.out_data, 8'h80);
    chk("msb0_count", count_a, 8'h01);
    a_if.in_data = 8'h00;
    step();
    chk("msb1_data", a_if.out_data, 8'h01);
    chk("msb1_count", count_a, 8'h00);
    chk("msb1_event", a_if.out_event, 1'b0);
    step();
    chk("msb2_data", a_if.out_data, 8'h00);
    chk("msb2_count", count_a, 8'hFF);
    chk("msb2_event", a_if.out_event, 1'b1);
    a_if.in_valid = 1'b0;
    step();

    // stall: consumer not ready for three cycles
    load_a = 1'b1; lv_a = 8'h10; mode_a = 2'b01;
    step();
    load_a = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_data = 8'h00; a_if.out_ready = 1'b0;
    step();
    chk("st0_data", a_if.out_data, 8'h10);
    chk("st0_in_ready", a_if.in_ready, 1'b0);
    a_if.in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_data", a_if.out_data, 8'h10);
      chk("st_hold_count", count_a, 8'h11);
      chk("st_hold_valid", a_if.out_valid, 1'b1);
    end
    a_if.out_ready = 1'b1;
    #1;
    chk("st_release_ready", a_if.in_ready, 1'b1);
    step();
    chk("st_next_data", a_if.out_data, 8'h44);
    chk("st_next_count", count_a, 8'h12);
    a_if.in_valid = 1'b0;
    step();

    // load coincident with accept, then wrap
    load_a = 1'b1; lv_a = 8'h05;
    step();
    a_if.in_valid = 1'b1; a_if.in_data = 8'h0F; lv_a = 8'hFE;
    step();
    load_a = 1'b0;
    chk("ldacc_data", a_if.out_data, 8'h0A);
    chk("ldacc_count", count_a, 8'hFE);
    chk("ldacc_event", a_if.out_event, 1'b0);
    a_if.in_data = 8'h00;
    step();
    chk("wr0_data", a_if.out_data, 8'hFE);
    chk("wr0_count", count_a, 8'hFF);
    step();
    chk("wr1_data", a_if.out_data, 8'hFF);
    chk("wr1_count", count_a, 8'h00);
    chk("wr1_event", a_if.out_event, 1'b1);
    a_if.in_valid = 1'b0;
    step();

    // saturating STEP=4 instance
    load_b = 1'b1; lv_b = 8'hFD;
    step();
    load_b = 1'b0;
    mode_b = 2'b01; b_if.in_valid = 1'b1; b_if.in_data = 8'h00;
    step();
    chk("sat0_data", b_if.out_data, 8'hFD);
    chk("sat0_count", count_b, 8'hFF);
    chk("sat0_event", b_if.out_event, 1'b1);
    step();
    chk("sat1_data", b_if.out_data, 8'hFF);
    chk("sat1_count", count_b, 8'hFF);
    chk("sat1_event", b_if.out_event, 1'b1);
    b_if.in_valid = 1'b0;
    load_b = 1'b1; lv_b = 8'h02;
    step();
    load_b = 1'b0;
    mode_b = 2'b10; b_if.in_valid = 1'b1;
    step();
    chk("satdn_data", b_if.out_data, 8'h02);
    chk("satdn_count", count_b, 8'h00);
    chk("satdn_event", b_if.out_event, 1'b1);
    mode_b = 2'b11; b_if.in_data = 8'h3C;
    step();
    chk("hold_data", b_if.out_data, 8'h3C);
    chk("hold_count", count_b, 8'h00);
    chk("hold_event", b_if.out_event, 1'b0);
    b_if.in_valid = 1'b0;
    step();

    // asynchronous clear while a word is held
    load_a = 1'b1; lv_a = 8'h37;
    step();
    load_a = 1'b0;
    mode_a = 2'b11; a_if.in_valid = 1'b1; a_if.in_data = 8'h00; a_if.out_ready = 1'b0;
    step();
    chk("pre_clr_valid", a_if.out_valid, 1'b1);
    chk("pre_clr_count", count_a, 8'h37);
    chk("pre_clr_data", a_if.out_data, 8'h37);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_valid", a_if.out_valid, 1'b0);
    chk("clr_data", a_if.out_data, 8'h00);
    chk("clr_count", count_a, 8'h00);
    chk("clr_event", a_if.out_event, 1'b0);
`ifdef COUNT_XOR_SCRAMBLER_PARITY_EN
    chk("clr_parity", a_if.out_parity, 1'b0);
`endif
    step();
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
